// File: rtl/coretest_host_if.sv
// coretest_host_if: request/response and byte-link signals of coretest_host
interface coretest_host_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_address;
    logic [31:0] req_write_data;
    logic        rsp_valid;
    logic [31:0] rsp_read_data;
    logic        rsp_error;
    logic        tx_syn;
    logic [7:0]  tx_data;
    logic        tx_ack;
    logic        rx_syn;
    logic [7:0]  rx_data;
    logic        rx_ack;
    modport master (
        output req_valid, req_we, req_address, req_write_data, tx_ack, rx_syn, rx_data,
        input  req_ready, rsp_valid, rsp_read_data, rsp_error, tx_syn, tx_data, rx_ack
    );
    modport slave (
        input  req_valid, req_we, req_address, req_write_data, tx_ack, rx_syn, rx_data,
        output req_ready, rsp_valid, rsp_read_data, rsp_error, tx_syn, tx_data, rx_ack
    );
endinterface

// File: rtl/coretest_host.sv
// coretest_host: coretest byte-protocol initiator; CORETEST_HOST_TIMEOUT_EN enables the response watchdog
module coretest_host #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic            clk,
    input logic            reset,
    coretest_host_if.slave bus
);
    typedef enum logic [1:0] {IDLE, TX, RX, DONE} state_t;
    state_t      state, state_next;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  tx_idx, rx_idx, rx_len;
    logic [7:0]  rx_code, cmd_byte, data_byte;
    logic [31:0] rd_shift;
    logic        tx_fire, tx_last, rx_fire, rx_last, byte_err, timeout;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    // next state and link/handshake outputs
    always_comb begin
        state_next = state;
        tx_fire = state == TX && bus.tx_ack;
        rx_fire = state == RX && bus.rx_syn;
        case (state)
            IDLE:    if (bus.req_valid) state_next = TX;
            TX:      if (tx_fire && tx_last) state_next = RX;
            RX:      if ((rx_fire && rx_last) || timeout) state_next = DONE;
            default: state_next = IDLE;
        endcase
        bus.req_ready = state == IDLE;
        bus.tx_syn = state == TX;
        bus.tx_data = state == TX ? cmd_byte : 8'h00;
        bus.rx_ack = state == RX || state == IDLE;
        bus.rsp_valid = state == DONE;
    end

    // command frame byte selected by the transmit index
    always_comb begin
        tx_last = tx_idx == (we ? 4'd8 : 4'd4);
        data_byte = tx_idx[1:0] == 2'd0 ? wdata[31:24] :
                    tx_idx[1:0] == 2'd1 ? wdata[23:16] :
                    tx_idx[1:0] == 2'd2 ? wdata[15:8] : wdata[7:0];
        cmd_byte = tx_idx == 4'd0 ? 8'h55 :
                   tx_idx == 4'd1 ? {7'h08, we} :
                   tx_idx == 4'd2 ? addr[15:8] :
                   tx_idx == 4'd3 ? addr[7:0] :
                   tx_last ? 8'hAA : data_byte;
    end

    // per-byte response checks; rx_last marks the byte that ends the frame
    always_comb begin
        byte_err = 1'b0;
        rx_last = 1'b0;
        if (rx_idx == 4'd0) begin
            byte_err = bus.rx_data != 8'hAA;
            rx_last = byte_err;
        end else if (rx_idx == 4'd1) begin
            byte_err = bus.rx_data != (we ? 8'h7E : 8'h7F);
            rx_last = !(bus.rx_data inside {8'h7F, 8'h7E, 8'hFE});
        end else if (rx_idx == rx_len - 4'd1) begin
            byte_err = bus.rx_data != 8'h55;
            rx_last = 1'b1;
        end else if (rx_code != 8'hFE && rx_idx == 4'd2) begin
            byte_err = bus.rx_data != addr[15:8];
        end else if (rx_code != 8'hFE && rx_idx == 4'd3) begin
            byte_err = bus.rx_data != addr[7:0];
        end
    end

`ifdef CORETEST_HOST_TIMEOUT_EN
    logic [31:0] wd;
    // watchdog counts silent RX cycles and restarts on every received byte
    always_ff @(posedge clk) begin
        if (reset || state != RX || rx_fire) wd <= '0;
        else wd <= wd + 32'd1;
    end
    assign timeout = state == RX && !rx_fire && wd == 32'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    // request latch, frame counters and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            we <= 1'b0;
            addr <= '0;
            wdata <= '0;
            tx_idx <= '0;
            rx_idx <= '0;
            rx_len <= 4'd4;
            rx_code <= '0;
            rd_shift <= '0;
            bus.rsp_read_data <= '0;
            bus.rsp_error <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                we <= bus.req_we;
                addr <= bus.req_address;
                wdata <= bus.req_write_data;
                tx_idx <= '0;
                rx_idx <= '0;
                bus.rsp_read_data <= '0;
                bus.rsp_error <= 1'b0;
            end
            if (tx_fire) tx_idx <= tx_idx + 4'd1;
            if (rx_fire) begin
                rx_idx <= rx_idx + 4'd1;
                rd_shift <= {rd_shift[23:0], bus.rx_data};
                if (rx_idx == 4'd1) begin
                    rx_code <= bus.rx_data;
                    rx_len <= bus.rx_data == 8'h7F ? 4'd9 : bus.rx_data == 8'h7E ? 4'd5 : 4'd4;
                end
                if (byte_err) bus.rsp_error <= 1'b1;
                if (rx_last && !we && rx_code == 8'h7F && !bus.rsp_error && !byte_err)
                    bus.rsp_read_data <= rd_shift;
            end
            if (timeout) bus.rsp_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_coretest_host.sv
// tb_coretest_host: directed and randomized checks of coretest_host against a frame-level model
module tb_coretest_host;
    typedef logic [7:0] bq_t[$];
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    coretest_host_if bus();
    coretest_host #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected command frame built directly from the protocol definition
    function automatic bq_t cmd_frame(input logic we, input logic [15:0] a, input logic [31:0] d);
        bq_t q;
        q = {8'h55, (we ? 8'h11 : 8'h10), a[15:8], a[7:0]};
        if (we) q = {q, d[31:24], d[23:16], d[15:8], d[7:0]};
        q.push_back(8'hAA);
        return q;
    endfunction

    // response model: bytes consumed, error flag and returned data for a whole frame
    function automatic void model(input logic we, input logic [15:0] a, input bq_t r,
                                  output int used, output logic err, output logic [31:0] data);
        int len;
        err = 1'b0;
        data = '0;
        if (r[0] != 8'hAA) begin
            used = 1;
            err = 1'b1;
            return;
        end
        if (r[1] == 8'h7F) len = 9;
        else if (r[1] == 8'h7E) len = 5;
        else if (r[1] == 8'hFE) len = 4;
        else begin
            used = 2;
            err = 1'b1;
            return;
        end
        used = len;
        if (r[1] != (we ? 8'h7E : 8'h7F)) err = 1'b1;
        if (r[1] != 8'hFE && {r[2], r[3]} != a) err = 1'b1;
        if (r[len-1] != 8'h55) err = 1'b1;
        if (!err && !we) data = {r[4], r[5], r[6], r[7]};
    endfunction

    // kind: 0 ok, 1 wrong code, 2 unknown-command reply, 3 bad sync, 4 bad address, 5 bad tail, 6 bad code
    function automatic bq_t gen_rsp(input logic we, input logic [15:0] a, input int kind);
        bq_t q;
        logic [31:0] d;
        logic [7:0] code;
        d = $urandom;
        code = we ? 8'h7E : 8'h7F;
        if (kind == 1) code = we ? 8'h7F : 8'h7E;
        if (kind == 2) code = 8'hFE;
        if (kind == 6) code = 8'h3C;
        q = {8'hAA, code};
        if (code == 8'hFE) q.push_back(8'hCC);
        else begin
            q.push_back(a[15:8]);
            q.push_back(kind == 4 ? a[7:0] ^ 8'h01 : a[7:0]);
            if (code == 8'h7F) q = {q, d[31:24], d[23:16], d[15:8], d[7:0]};
        end
        q.push_back(kind == 5 ? 8'h5A : 8'h55);
        if (kind == 3) q[0] = 8'h5A;
        return q;
    endfunction

    task automatic start_req(input logic we, input logic [15:0] a, input logic [31:0] d);
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_address = a;
        bus.req_write_data = d;
        tick();
        bus.req_valid = 1'b0;
        chk("req_ready_busy", bus.req_ready, 0);
    endtask

    // mode 0: ack always, 1: ack toggling 1/0, 2: random ack
    task automatic collect_tx(input int mode, output bq_t got);
        int n = 0;
        got = {};
        while (bus.tx_syn && n < 100) begin
            bus.tx_ack = mode == 0 ? 1'b1 : mode == 1 ? ((n % 2) == 0) : 1'($urandom_range(1));
            if (bus.tx_ack) got.push_back(bus.tx_data);
            tick();
            n++;
        end
        bus.tx_ack = 1'b0;
    endtask

    task automatic check_tx(input bq_t exp, input bq_t got);
        chk("tx_len", got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk("tx_byte", got[i], exp[i]);
    endtask

    task automatic feed_rx(input bq_t rsp, input bit gaps, output int used, output logic seen,
                           output logic [31:0] data, output logic err);
        int i = 0;
        int n = 0;
        bit fired;
        seen = 1'b0;
        data = '0;
        err = 1'b0;
        while (!seen && n < 300) begin
            if (i < rsp.size() && !(gaps && $urandom_range(3) == 0)) begin
                bus.rx_syn = 1'b1;
                bus.rx_data = rsp[i];
            end else begin
                bus.rx_syn = 1'b0;
                bus.rx_data = 8'h00;
            end
            fired = bus.rx_syn && bus.rx_ack;
            tick();
            n++;
            if (fired) i++;
            if (bus.rsp_valid) begin
                seen = 1'b1;
                data = bus.rsp_read_data;
                err = bus.rsp_error;
                bus.rx_syn = 1'b0;
            end
        end
        bus.rx_syn = 1'b0;
        used = i;
    endtask

    task automatic run_txn(input logic we, input logic [15:0] a, input logic [31:0] d,
                           input bq_t rsp, input int tx_mode, input bit gaps);
        bq_t got;
        int used, m_used;
        logic seen, err, m_err;
        logic [31:0] data, m_data;
        start_req(we, a, d);
        collect_tx(tx_mode, got);
        check_tx(cmd_frame(we, a, d), got);
        model(we, a, rsp, m_used, m_err, m_data);
        feed_rx(rsp, gaps, used, seen, data, err);
        chk("rsp_seen", seen, 1);
        chk("rx_consumed", used, m_used);
        chk("rsp_error", err, m_err);
        chk("rsp_read_data", data, m_data);
        tick();
        chk("rsp_pulse_one_cycle", bus.rsp_valid, 0);
        chk("req_ready_after_done", bus.req_ready, 1);
        chk("rsp_hold", {bus.rsp_error, bus.rsp_read_data}, {m_err, m_data});
    endtask

    initial begin
        logic we;
        logic [15:0] a;
        logic [31:0] d;
        int kind;
        int n;
        logic seen;
        bq_t got;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_address = '0;
        bus.req_write_data = '0;
        bus.tx_ack = 1'b0;
        bus.rx_syn = 1'b0;
        bus.rx_data = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_tx_syn", bus.tx_syn, 0);
        chk("reset_tx_data", bus.tx_data, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_read_data", bus.rsp_read_data, 0);
        chk("reset_rsp_error", bus.rsp_error, 0);
        chk("reset_rx_ack", bus.rx_ack, 1);

        // bytes arriving while idle are swallowed without effect
        foreach (got[i]) got.delete();
        for (int i = 0; i < 3; i++) begin
            bus.rx_syn = 1'b1;
            bus.rx_data = i == 0 ? 8'hAA : 8'h7F;
            tick();
            chk("idle_no_rsp", bus.rsp_valid, 0);
            chk("idle_rx_ack", bus.rx_ack, 1);
        end
        bus.rx_syn = 1'b0;

        run_txn(1'b0, 16'h1020, 32'h0,
                {8'hAA, 8'h7F, 8'h10, 8'h20, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55}, 0, 1'b0);
        chk("read_deadbeef", bus.rsp_read_data, 32'hDEADBEEF);
        run_txn(1'b1, 16'h0008, 32'h1, {8'hAA, 8'h7E, 8'h00, 8'h08, 8'h55}, 1, 1'b0);
        run_txn(1'b0, 16'h1000, 32'h0, {8'hAA, 8'hFE, 8'h10, 8'h55}, 0, 1'b0);
        chk("unknown_error", bus.rsp_error, 1);
        run_txn(1'b0, 16'h1000, 32'h0,
                {8'hAA, 8'h7F, 8'h10, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55}, 0, 1'b0);
        chk("addr_mismatch_error", bus.rsp_error, 1);
        run_txn(1'b0, 16'h1000, 32'h0,
                {8'h5A, 8'h7F, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55}, 0, 1'b0);

        // reset in the middle of a command frame aborts silently
        start_req(1'b0, 16'h2222, 32'h0);
        bus.tx_ack = 1'b1;
        tick();
        tick();
        tick();
        bus.tx_ack = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_tx_syn", bus.tx_syn, 0);
        chk("abort_req_ready", bus.req_ready, 1);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= bus.rsp_valid;
        end
        chk("abort_no_rsp", seen, 0);
        run_txn(1'b0, 16'h3344, 32'h0,
                {8'hAA, 8'h7F, 8'h33, 8'h44, 8'h01, 8'h23, 8'h45, 8'h67, 8'h55}, 0, 1'b0);

        // read with no response at all
        start_req(1'b0, 16'h0BAD, 32'h0);
        collect_tx(0, got);
        check_tx(cmd_frame(1'b0, 16'h0BAD, 32'h0), got);
`ifdef CORETEST_HOST_TIMEOUT_EN
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_error", bus.rsp_error, 1);
        chk("timeout_data", bus.rsp_read_data, 0);
        tick();
`else
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            seen |= bus.rsp_valid;
        end
        chk("no_timeout", seen, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif

        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom_range(1));
            a = 16'($urandom);
            d = $urandom;
            kind = $urandom_range(0, 11);
            if (kind > 6) kind = 0;
            run_txn(we, a, d, gen_rsp(we, a, kind), $urandom_range(2), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
